comparator_seq_word: RTL
========================

COMPARATOR_SEQ_WORD -- requirements
Module: comparator_seq_word

Interface
REQ-001 Parameter NBYTES, default 4, operand width in bytes; SHALL be >= 2.
REQ-002 clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a comparison; sampled only in IDLE or DONE.
REQ-005 A  input  8*NBYTES  operand A; sampled on an accepted start.
REQ-006 B  input  8*NBYTES  operand B; sampled on an accepted start.
REQ-007 l, e, g  input  1 each  cascade-in flags; sampled on an accepted start.
REQ-008 busy  output  1  high while bytes are being compared.
REQ-009 done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 lt, et, gt  output  1 each  registered result flags; held until the next accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 at edge T SHALL latch A, B, l, e and g, set the byte index to NBYTES-1, and enter RUN.
REQ-013 In RUN, each cycle SHALL compare one byte pair, MSB byte first, using the cascade rule in REQ-014.
REQ-014 Cascade rule: byte A > byte B gives gt; byte A < byte B gives lt; equal bytes carry the incoming flags forward unchanged.
REQ-015 A byte pair that differs SHALL terminate RUN early: the flags are registered and the FSM enters DONE.
REQ-016 If all bytes are equal, the outputs SHALL equal the latched l/e/g verbatim, including non-one-hot values.
REQ-017 Latency: if k bytes are processed (1 <= k <= NBYTES), done=1 and the result is valid in cycle T+1+k.
REQ-018 DONE SHALL last exactly one cycle and return to IDLE, unless start=1 in that cycle, which is accepted per REQ-012.
REQ-019 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-020 start=1 during RUN SHALL be ignored, with no effect on the latched operands or the result.
REQ-021 lt/et/gt SHALL NOT change between a done pulse and the next done pulse.
REQ-022 The byte index SHALL be $clog2(NBYTES) bits wide.
REQ-023 The byte index SHALL NOT wrap; reaching index 0 always ends RUN.

Reset
REQ-024 While rst_n=0, asynchronously: state=IDLE, busy=0, done=0, lt=0, et=1, gt=0, index=0, and operand registers cleared.
REQ-025 Reset asserted mid-RUN SHALL abort the comparison with no done pulse.
REQ-026 After reset is released, the first start SHALL behave per REQ-012.

Configuration
REQ-027 Macro COMPARATOR_SEQ_SIGNED_EN selects the signedness of the compare.
REQ-028 With COMPARATOR_SEQ_SIGNED_EN defined, the most significant byte pair SHALL be compared as two's-complement signed and the lower bytes as unsigned.
REQ-029 Without the macro, all bytes SHALL be compared unsigned.

Structure
REQ-030 Package comparator_pkg SHALL hold the state enum (IDLE/RUN/DONE), BYTE_W=8, and the reset flag constants.
REQ-031 Sub-module comparator_byte SHALL be the combinational 8-bit cascade compare.
  - Inputs: a, b, l, e, g, signed_sel.
  - Outputs: lt, et, gt.
REQ-032 comparator_seq_word SHALL instantiate exactly one comparator_byte, muxed by the byte index.

Verification (NBYTES=4, start at edge T, cascade in l/e/g=0/1/0 unless noted)
REQ-033 A=B=0x00000000 -> busy in T+1..T+4, done at T+5, et=1, lt=0, gt=0.
REQ-034 A=0x49000000, B=0x22000000 -> early exit with done at T+2, gt=1.
  - A second case: A=0x4B0000AB, B=0x4B0000CD -> done at T+5, lt=1.
REQ-035 A=B=0xCBCBCBCB with l/e/g=1/0/0 -> done at T+5, lt=1 (cascade passthrough).
REQ-036 A=0x80000000, B=0x7F000000 -> gt=1 without COMPARATOR_SEQ_SIGNED_EN; lt=1 with it.
REQ-037 Control-path cases:
  - start pulsed at T+2 during RUN -> ignored, and the original result is produced.
  - rst_n low at T+2 -> no done pulse, outputs reset to 0/1/0.
  - start=1 in the DONE cycle -> the next comparison begins back-to-back.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and constants for the sequential byte-serial word comparator.
// FSM state encoding, byte width and the flag values the result registers reset to.
package comparator_pkg;

  localparam int BYTE_W = 8;

  // Result flags after reset: "equal" with neither less-than nor greater-than.
  localparam logic RST_LT = 1'b0;
  localparam logic RST_ET = 1'b1;
  localparam logic RST_GT = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic et;
    logic gt;
  } flags_t;

  localparam flags_t RST_FLAGS = '{lt: RST_LT, et: RST_ET, gt: RST_GT};

  // Flags produced by a byte pair that differs; equal pairs pass the cascade through.
  localparam flags_t FLAGS_LT = '{lt: 1'b1, et: 1'b0, gt: 1'b0};
  localparam flags_t FLAGS_GT = '{lt: 1'b0, et: 1'b0, gt: 1'b1};

endpackage : comparator_pkg

// File: rtl/comparator_byte.sv
// Combinational 8-bit cascade compare: a difference decides the result,
// equal bytes forward the incoming l/e/g flags untouched.
module comparator_byte
  import comparator_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              l,
  input  logic              e,
  input  logic              g,
  input  logic              signed_sel,
  output logic              lt,
  output logic              et,
  output logic              gt
);

  logic a_gt_b;
  logic a_lt_b;

  always_comb begin
    if (signed_sel) begin
      a_gt_b = $signed(a) > $signed(b);
      a_lt_b = $signed(a) < $signed(b);
    end else begin
      a_gt_b = a > b;
      a_lt_b = a < b;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
    lt = l;
    et = e;
    gt = g;
    if (a_gt_b) begin
      {lt, et, gt} = FLAGS_GT;
    end else if (a_lt_b) begin
      {lt, et, gt} = FLAGS_LT;
    end
  end

endmodule : comparator_byte

// File: rtl/comparator_seq_word.sv
// Byte-serial magnitude comparator: one byte pair per cycle, MSB first, early exit on
// the first difference. Define COMPARATOR_SEQ_SIGNED_EN to treat the top byte as signed.
module comparator_seq_word
  import comparator_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [8*NBYTES-1:0]      A,
  input  logic [8*NBYTES-1:0]      B,
  input  logic                     l,
  input  logic                     e,
  input  logic                     g,
  output logic                     busy,
  output logic                     done,
  output logic                     lt,
  output logic                     et,
  output logic                     gt
);

  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NBYTES - 1);

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [NBYTES-1:0][BYTE_W-1:0]   a_q;
  logic [NBYTES-1:0][BYTE_W-1:0]   b_q;
  flags_t                          cas_q;

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic              signed_sel;
  logic              byte_differs;
  logic              last_byte;
  logic              cmp_lt;
  logic              cmp_et;
  logic              cmp_gt;

  assign a_byte       = a_q[idx];
  assign b_byte       = b_q[idx];
  assign byte_differs = (a_byte != b_byte);
  assign last_byte    = (idx == '0);

`ifdef COMPARATOR_SEQ_SIGNED_EN
  // Only the most significant byte carries the sign; lower bytes are magnitude.
  assign signed_sel = (idx == IDX_MSB);
`else
  assign signed_sel = 1'b0;
`endif

  comparator_byte u_byte (
    .a          (a_byte),
    .b          (b_byte),
    .l          (cas_q.lt),
    .e          (cas_q.et),
    .g          (cas_q.gt),
    .signed_sel (signed_sel),
    .lt         (cmp_lt),
    .et         (cmp_et),
    .gt         (cmp_gt)
  );

  // Equal bytes leave the cascade unchanged, so the latched flags feed every byte
  // and only the terminating byte's result is ever registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too, so no stale operand survives an aborted run.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= RST_LT;
      et    <= RST_ET;
      gt    <= RST_GT;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cas_q <= RST_FLAGS;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            cas_q <= '{lt: l, et: e, gt: g};
            idx   <= IDX_MSB;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          if (byte_differs || last_byte) begin
            lt    <= cmp_lt;
            et    <= cmp_et;
            gt    <= cmp_gt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : comparator_seq_word
